// File: rtl/cross_acc_pkg.sv
// Shared types and default widths for the cross-coupled accumulator sequencer.
package cross_acc_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 40;
    localparam int DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cross_acc_dp.sv
// Cross-coupled accumulator pair with clear/enable and the combinational result adder.
module cross_acc_dp
    import cross_acc_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_in1,
    input  logic [DW-1:0] i_in2,
    output logic [AW-1:0] o_sum
);

    logic [AW-1:0] r_acc_0;
    logic [AW-1:0] r_acc_1;
    logic [AW-1:0] w_in1_ext;
    logic [AW-1:0] w_in2_ext;

    assign w_in1_ext = {{(AW-DW){1'b0}}, i_in1};
    assign w_in2_ext = {{(AW-DW){1'b0}}, i_in2};
    assign o_sum     = r_acc_0 + r_acc_1;

    // Both updates use the pre-edge value of the opposite accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_0 <= '0;
            r_acc_1 <= '0;
        end else if (i_clr) begin
            r_acc_0 <= '0;
            r_acc_1 <= '0;
        end else if (i_en) begin
            r_acc_0 <= w_in1_ext + r_acc_1;
            r_acc_1 <= w_in2_ext + r_acc_0;
        end
    end

endmodule

// File: rtl/cross_acc_seq_ctrl.sv
// Burst sequencer: captures a length, consumes N sample pairs, then presents the sum.
//   state | meaning
//   IDLE  | waiting for start; no handshakes active
//   RUN   | accepting sample pairs until N beats are consumed
//   DONE  | result valid, held until the consumer accepts
module cross_acc_seq_ctrl
    import cross_acc_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in1,
    input  logic [DW-1:0]    in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_sum
);

    seq_state_t       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             w_beat;
    logic             w_last;
    logic             w_clr;
    logic             w_en;

    assign in_ready  = (r_state == ST_RUN);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);

    assign w_beat = in_valid & in_ready;
    assign w_last = (r_cnt == r_len - 1'b1);
    assign w_clr  = abort | ((r_state == ST_IDLE) & start);
    assign w_en   = w_beat & ~abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len   <= len;
                        r_cnt   <= '0;
                        r_state <= (len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    cross_acc_dp #(
        .DW (DW),
        .AW (AW)
    ) u_dp (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (w_en),
        .i_in1 (in1),
        .i_in2 (in2),
        .o_sum (out_sum)
    );

endmodule

// File: tb/tb_cross_acc_seq_ctrl.sv
// Directed bench for cross_acc_seq_ctrl: bursts, gaps, backpressure, zero length, abort, reset.
module tb_cross_acc_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_sum;

    int n_tests = 0;
    int n_fail  = 0;

    int a_in1 [4] = '{100, 20, 10, 100};
    int a_in2 [4] = '{50, 25, 30, 20};
    int a_acc0[4] = '{100, 70, 135, 200};
    int a_acc1[4] = '{50, 125, 100, 155};
    int a_sum [4] = '{150, 195, 235, 355};

    cross_acc_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive_beats(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            in_valid = 1'b1;
            in1 = a_in1[i];
            in2 = a_in2[i];
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic start_burst(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        n_tests++;
        if ({busy, in_ready, out_valid} !== 3'b000) begin
            $display("FAIL reset_flags: got %b want 000", {busy, in_ready, out_valid});
            n_fail++;
        end
        n_tests++;
        if (out_sum !== 40'd0) begin
            $display("FAIL reset_sum: got %0d want 0", out_sum);
            n_fail++;
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        start_burst(8'd4);
        n_tests++;
        if ({busy, in_ready, out_valid} !== 3'b110) begin
            $display("FAIL basic_run_flags: got %b want 110", {busy, in_ready, out_valid});
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (out_valid !== 1'b0) begin
                $display("FAIL basic_early_valid beat %0d: got %b want 0", i, out_valid);
                n_fail++;
            end
            in_valid = 1'b1;
            in1 = a_in1[i];
            in2 = a_in2[i];
            cyc();
            n_tests++;
            if (dut.u_dp.r_acc_0 !== 40'(a_acc0[i]) || dut.u_dp.r_acc_1 !== 40'(a_acc1[i])) begin
                $display("FAIL basic_acc beat %0d: got (%0d,%0d) want (%0d,%0d)", i,
                         dut.u_dp.r_acc_0, dut.u_dp.r_acc_1, a_acc0[i], a_acc1[i]);
                n_fail++;
            end
            n_tests++;
            if (out_sum !== 40'(a_sum[i])) begin
                $display("FAIL basic_live_sum beat %0d: got %0d want %0d", i, out_sum, a_sum[i]);
                n_fail++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 40'd355) begin
            $display("FAIL basic_done: got valid=%b ready=%b sum=%0d want 1 0 355",
                     out_valid, in_ready, out_sum);
            n_fail++;
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL basic_idle: got busy=%b valid=%b want 0 0", busy, out_valid);
            n_fail++;
        end
    endtask

    task automatic test_gaps();
        start_burst(8'd4);
        drive_beats(0, 1);
        for (int g = 0; g < 2; g++) begin
            cyc();
            n_tests++;
            if (in_ready !== 1'b1 || out_sum !== 40'd195) begin
                $display("FAIL gap_hold %0d: got ready=%b sum=%0d want 1 195", g, in_ready, out_sum);
                n_fail++;
            end
        end
        drive_beats(2, 3);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 40'd355) begin
            $display("FAIL gap_done: got ready=%b valid=%b sum=%0d want 0 1 355",
                     in_ready, out_valid, out_sum);
            n_fail++;
        end
        // An extra offered sample must not be consumed.
        in_valid = 1'b1;
        in1 = 32'd7;
        in2 = 32'd9;
        cyc();
        in_valid = 1'b0;
        n_tests++;
        if (out_sum !== 40'd355 || dut.r_cnt !== 8'd4) begin
            $display("FAIL gap_extra: got sum=%0d cnt=%0d want 355 4", out_sum, dut.r_cnt);
            n_fail++;
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        start_burst(8'd4);
        drive_beats(0, 3);
        for (int c = 0; c < 5; c++) begin
            start = (c == 1 || c == 2);
            len   = 8'd1;
            cyc();
            n_tests++;
            if (out_valid !== 1'b1 || out_sum !== 40'd355) begin
                $display("FAIL bp_hold %0d: got valid=%b sum=%0d want 1 355", c, out_valid, out_sum);
                n_fail++;
            end
        end
        n_tests++;
        if (dut.r_len !== 8'd4) begin
            $display("FAIL bp_len: got %0d want 4", dut.r_len);
            n_fail++;
        end
        start = 1'b1;
        out_ready = 1'b1;
        cyc();
        start = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL bp_idle: got busy=%b valid=%b want 0 0", busy, out_valid);
            n_fail++;
        end
        cyc();
        n_tests++;
        if (busy !== 1'b0 || out_sum !== 40'd355) begin
            $display("FAIL bp_start_ignored: got busy=%b sum=%0d want 0 355", busy, out_sum);
            n_fail++;
        end
    endtask

    task automatic test_zero_wide();
        start_burst(8'd0);
        n_tests++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || out_sum !== 40'd0) begin
            $display("FAIL zero_len: got valid=%b busy=%b ready=%b sum=%0d want 1 1 0 0",
                     out_valid, busy, in_ready, out_sum);
            n_fail++;
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        start_burst(8'd1);
        in_valid = 1'b1;
        in1 = 32'hFFFF_FFFF;
        in2 = 32'hFFFF_FFFF;
        cyc();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_sum !== 40'h01_FFFF_FFFE) begin
            $display("FAIL wide_sum: got valid=%b sum=%h want 1 01fffffffe", out_valid, out_sum);
            n_fail++;
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        start_burst(8'd4);
        drive_beats(0, 1);
        abort = 1'b1;
        in_valid = 1'b1;
        in1 = a_in1[2];
        in2 = a_in2[2];
        cyc();
        abort = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if ({busy, in_ready, out_valid} !== 3'b000 || out_sum !== 40'd0) begin
            $display("FAIL abort_idle: got flags=%b sum=%0d want 000 0", {busy, in_ready, out_valid}, out_sum);
            n_fail++;
        end
        cyc();
        n_tests++;
        if (out_valid !== 1'b0 || dut.r_cnt !== 8'd0) begin
            $display("FAIL abort_stays: got valid=%b cnt=%0d want 0 0", out_valid, dut.r_cnt);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_run();
        start_burst(8'd4);
        drive_beats(0, 1);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, in_ready, out_valid} !== 3'b000 || out_sum !== 40'd0) begin
            $display("FAIL rst_mid: got flags=%b sum=%0d want 000 0", {busy, in_ready, out_valid}, out_sum);
            n_fail++;
        end
        cyc();
        rst = 1'b1;
        cyc();
        start_burst(8'd4);
        drive_beats(0, 3);
        n_tests++;
        if (out_valid !== 1'b1 || out_sum !== 40'd355) begin
            $display("FAIL rst_rerun: got valid=%b sum=%0d want 1 355", out_valid, out_sum);
            n_fail++;
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        len = 8'd0;
        abort = 1'b0;
        in_valid = 1'b0;
        in1 = 32'd0;
        in2 = 32'd0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_back_pressure();
        test_zero_wide();
        test_abort();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
